// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-scanline OAM scan that builds the line sprite list.
//
// Ports:
//   clk, rst         - rising-edge clock, synchronous active-high reset
//   line_start_i     - one-cycle request to evaluate next_line_i (ignored unless idle)
//   next_line_i      - game-window Y of the line to evaluate
//   oam_rd_en_o      - OAM read strobe, one entry per cycle during the scan
//   oam_rd_addr_o    - OAM entry index
//   oam_rd_data_i    - {valid, y, x, tile}, returned the cycle after the strobe
//   list_wr_en_o     - line list write strobe
//   list_wr_addr_o   - line list slot
//   list_wr_data_o   - {x, tile, row}
//   list_count_o     - sprites written for the current line
//   overflow_o       - more than LINE_MAX sprites intersect the line
//   busy_o           - scan in progress
//   done_o           - one-cycle pulse when the list is complete
module sprite_line_scheduler #(
    parameter int SPRITE_NUM = 32,
    parameter int LINE_MAX   = 8,
    parameter int POS_BIT    = 10,
    parameter int SPRITE_H   = 16,
    parameter int TILE_BIT   = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          line_start_i,
    input  logic [POS_BIT-1:0]                            next_line_i,
    output logic                                          oam_rd_en_o,
    output logic [$clog2(SPRITE_NUM)-1:0]                 oam_rd_addr_o,
    input  logic [2*POS_BIT+TILE_BIT:0]                   oam_rd_data_i,
    output logic                                          list_wr_en_o,
    output logic [$clog2(LINE_MAX)-1:0]                   list_wr_addr_o,
    output logic [POS_BIT+TILE_BIT+$clog2(SPRITE_H)-1:0]  list_wr_data_o,
    output logic [$clog2(LINE_MAX):0]                     list_count_o,
    output logic                                          overflow_o,
    output logic                                          busy_o,
    output logic                                          done_o
);
    localparam int AW = $clog2(SPRITE_NUM);
    localparam int LW = $clog2(LINE_MAX);
    localparam int RW = $clog2(SPRITE_H);
    localparam int DW = 2 * POS_BIT + TILE_BIT + 1;
    localparam logic [AW-1:0] IDX_LAST = AW'(SPRITE_NUM - 1);
    localparam logic [LW:0]   CNT_MAX  = (LW + 1)'(LINE_MAX);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [POS_BIT-1:0] line_q, line_d;
    logic [LW:0]        count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               cmp_q;

    logic               valid;
    logic [POS_BIT-1:0] spr_y, spr_x;
    logic [TILE_BIT-1:0] spr_tile;
    logic [POS_BIT:0]   diff;
    logic               hit, room, wr_en;

    assign valid    = oam_rd_data_i[DW-1];
    assign spr_y    = oam_rd_data_i[DW-2 -: POS_BIT];
    assign spr_x    = oam_rd_data_i[TILE_BIT +: POS_BIT];
    assign spr_tile = oam_rd_data_i[TILE_BIT-1:0];

    // One extra bit catches line < y as a borrow instead of wrapping; with
    // SPRITE_H a power of two, all upper bits zero means 0 <= diff < SPRITE_H.
    assign diff  = {1'b0, line_q} - {1'b0, spr_y};
    assign hit   = cmp_q && valid && (diff[POS_BIT:RW] == '0);
    assign room  = count_q < CNT_MAX;
    assign wr_en = hit && room;

    assign oam_rd_en_o    = state_q == SCAN;
    assign oam_rd_addr_o  = idx_q;
    assign list_wr_en_o   = wr_en;
    assign list_wr_addr_o = wr_en ? count_q[LW-1:0] : '0;
    assign list_wr_data_o = wr_en ? {spr_x, spr_tile, diff[RW-1:0]} : '0;
    assign list_count_o   = count_q;
    assign overflow_o     = ovf_q;
    assign busy_o         = (state_q == SCAN) || (state_q == DRAIN);
    assign done_o         = state_q == FIN;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        line_d  = line_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (line_start_i) begin
                state_d = SCAN;
                idx_d   = '0;
                line_d  = next_line_i;
                count_d = '0;
                ovf_d   = 1'b0;
            end
            SCAN: begin
                idx_d   = idx_q + AW'(1);
                state_d = (idx_q == IDX_LAST) ? DRAIN : SCAN;
            end
            DRAIN: state_d = FIN;
            default: state_d = IDLE;
        endcase
        if (wr_en) count_d = count_q + (LW + 1)'(1);
        if (hit && !room) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            line_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            cmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            // read data returns one cycle after the strobe, so compare then
            cmp_q   <= state_q == SCAN;
        end
    end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: directed self-checking bench for sprite_line_scheduler.
module tb_sprite_line_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_start = 1'b0;
    logic [9:0]  next_line = '0;
    logic        oam_rd_en;
    logic [4:0]  oam_rd_addr;
    logic [28:0] oam_rd_data;
    logic        list_wr_en;
    logic [2:0]  list_wr_addr;
    logic [21:0] list_wr_data;
    logic [3:0]  list_count;
    logic        overflow, busy, done;

    sprite_line_scheduler dut (
        .clk(clk), .rst(rst), .line_start_i(line_start), .next_line_i(next_line),
        .oam_rd_en_o(oam_rd_en), .oam_rd_addr_o(oam_rd_addr), .oam_rd_data_i(oam_rd_data),
        .list_wr_en_o(list_wr_en), .list_wr_addr_o(list_wr_addr), .list_wr_data_o(list_wr_data),
        .list_count_o(list_count), .overflow_o(overflow), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    logic [28:0] oam [0:31];
    always @(posedge clk) if (oam_rd_en) oam_rd_data <= oam[oam_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        arm = 1'b0;
    int          base = 0, rd_n = 0, wr_n = 0, done_n = 0, busy_n = 0, done_rel = 0;
    int          rd_addr [0:63];
    int          rd_rel  [0:63];
    int          wr_rel  [0:15];
    logic [2:0]  wr_addr [0:15];
    logic [21:0] wr_data [0:15];

    always @(negedge clk) begin
        if (arm) begin
            base   <= cyc;
            rd_n   <= 0;
            wr_n   <= 0;
            done_n <= 0;
            busy_n <= 0;
        end else begin
            if (oam_rd_en) begin
                if (rd_n < 64) begin
                    rd_addr[rd_n] <= int'(oam_rd_addr);
                    rd_rel[rd_n]  <= cyc - base;
                end
                rd_n <= rd_n + 1;
            end
            if (list_wr_en) begin
                if (wr_n < 16) begin
                    wr_addr[wr_n] <= list_wr_addr;
                    wr_data[wr_n] <= list_wr_data;
                    wr_rel[wr_n]  <= cyc - base;
                end
                wr_n <= wr_n + 1;
            end
            if (done) begin
                done_n   <= done_n + 1;
                done_rel <= cyc - base;
            end
            if (busy) busy_n <= busy_n + 1;
        end
    end

    int vec = 0, miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spr(input int i, input logic v, input logic [9:0] y, input logic [9:0] x,
                       input logic [7:0] t);
        oam[i] = {v, y, x, t};
    endtask

    task automatic clr();
        for (int j = 0; j < 32; j++) oam[j] = '0;
    endtask

    task automatic start(input logic [9:0] ln);
        @(posedge clk); #1;
        line_start = 1'b1;
        next_line  = ln;
        arm        = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        arm        = 1'b0;
    endtask

    task automatic run(input logic [9:0] ln);
        start(ln);
        repeat (40) @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        logic [21:0] e;
        clr();
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", oam_rd_en, 0);
        chk("rst_rd_addr", oam_rd_addr, 0);
        chk("rst_wr_en", list_wr_en, 0);
        chk("rst_wr_addr", list_wr_addr, 0);
        chk("rst_wr_data", list_wr_data, 0);
        chk("rst_count", list_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // all entries invalid
        run(10'd50);
        chk("empty_rd_n", rd_n, 32);
        bad = 0;
        for (int j = 0; j < 32; j++) if (rd_addr[j] != j || rd_rel[j] != j + 1) bad++;
        chk("empty_rd_seq", bad, 0);
        chk("empty_wr_n", wr_n, 0);
        chk("empty_done_n", done_n, 1);
        chk("empty_done_rel", done_rel, 34);
        chk("empty_busy_n", busy_n, 33);
        chk("empty_count", list_count, 0);
        chk("empty_ovf", overflow, 0);

        // single sprite, row boundaries
        spr(5, 1'b1, 10'd100, 10'd40, 8'd7);
        run(10'd100);
        chk("s5_row0_wr_n", wr_n, 1);
        chk("s5_row0_addr", wr_addr[0], 0);
        chk("s5_row0_data", wr_data[0], {10'd40, 8'd7, 4'd0});
        chk("s5_row0_rel", wr_rel[0], 7);
        chk("s5_row0_count", list_count, 1);
        run(10'd115);
        chk("s5_row15_wr_n", wr_n, 1);
        chk("s5_row15_data", wr_data[0], {10'd40, 8'd7, 4'd15});
        run(10'd116);
        chk("s5_below_wr_n", wr_n, 0);
        chk("s5_below_count", list_count, 0);
        run(10'd99);
        chk("s5_above_wr_n", wr_n, 0);

        // ten sprites on one line: first eight kept, overflow flagged
        clr();
        for (int j = 0; j < 10; j++) spr(j, 1'b1, 10'd60, 10'(10 * j + 1), 8'(j + 16));
        run(10'd65);
        chk("ovf_wr_n", wr_n, 8);
        bad = 0;
        for (int j = 0; j < 8; j++) begin
            e = {10'(10 * j + 1), 8'(j + 16), 4'd5};
            if (wr_addr[j] != 3'(j) || wr_data[j] != e) bad++;
        end
        chk("ovf_slots", bad, 0);
        chk("ovf_count", list_count, 8);
        chk("ovf_flag", overflow, 1);

        // no wrap near the top of the coordinate range; y=0 hits line 0
        clr();
        spr(3, 1'b1, 10'd1020, 10'd9, 8'd2);
        run(10'd3);
        chk("nowrap_wr_n", wr_n, 0);
        chk("nowrap_ovf", overflow, 0);
        spr(3, 1'b1, 10'd0, 10'd9, 8'd2);
        run(10'd0);
        chk("y0_wr_n", wr_n, 1);
        chk("y0_data", wr_data[0], {10'd9, 8'd2, 4'd0});

        // line_start while busy, during done, and the cycle after done
        start(10'd0);
        repeat (9) @(posedge clk);
        #1 line_start = 1'b1;
        @(posedge clk);
        #1 line_start = 1'b0;
        repeat (23) @(posedge clk);
        #1;
        chk("busy_ls_done_hi", done, 1);
        line_start = 1'b1;
        @(posedge clk); #1;
        chk("busy_ls_idle", busy, 0);
        chk("busy_ls_done_n", done_n, 1);
        chk("busy_ls_done_rel", done_rel, 34);
        arm = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        arm = 1'b0;
        chk("restart_busy", busy, 1);
        repeat (40) @(posedge clk);
        #1;
        chk("restart_done_n", done_n, 1);
        chk("restart_done_rel", done_rel, 34);
        chk("restart_rd_n", rd_n, 32);

        // reset mid-scan after three hits
        clr();
        spr(0, 1'b1, 10'd60, 10'd0, 8'd0);
        spr(2, 1'b1, 10'd60, 10'd2, 8'd2);
        spr(5, 1'b1, 10'd60, 10'd5, 8'd5);
        spr(20, 1'b1, 10'd60, 10'd20, 8'd20);
        start(10'd65);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_count", list_count, 3);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_rd_en", oam_rd_en, 0);
        chk("mrst_count", list_count, 0);
        chk("mrst_done", done, 0);
        chk("mrst_wr_en", list_wr_en, 0);
        chk("mrst_ovf", overflow, 0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("mrst_no_done", done_n, 0);
        run(10'd65);
        chk("post_wr_n", wr_n, 4);
        chk("post_last", wr_data[3], {10'd20, 8'd20, 4'd5});
        chk("post_last_rel", wr_rel[3], 22);
        chk("post_count", list_count, 4);
        chk("post_done_rel", done_rel, 34);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
